instr_queue: RTL and testbench
==============================

# instr_queue

Parametrised in-order instruction queue between the instruction register/fetch stage and the issue logic of the Tomasulo core. It buffers fetched instruction words with their PCs, has valid/ready handshakes on both sides, and reports occupancy for fetch throttling. It generalises the fixed single-entry IR→IQ hand-off to a configurable depth and width. A single-cycle flush discards all buffered instructions on branch mispredict.

## Interface
- WIDTH, 32, instruction word width in bits
- PC_WIDTH, 32, PC width in bits
- DEPTH, 8, number of entries; power of two, ≥ 2
- AFULL_THRESH, DEPTH-2, occupancy at or above which almost_full asserts; range 1..DEPTH

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  discard all entries (branch mispredict)
- enq_valid  in  1  producer offers an entry
- enq_ready  out  1  queue accepts an entry this cycle
- enq_instr  in  WIDTH  instruction word to enqueue
- enq_pc  in  PC_WIDTH  PC of enq_instr
- deq_valid  out  1  head entry is available
- deq_ready  in  1  consumer takes the head this cycle
- deq_instr  out  WIDTH  head instruction word
- deq_pc  out  PC_WIDTH  head PC
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_THRESH

## Operation
- Storage: DEPTH-entry circular buffer of {instr, pc}. Head and tail pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. A separate count register holds occupancy.
- Enqueue fires when enq_valid && enq_ready. The entry is written at tail, and tail increments.
- Dequeue fires when deq_valid && deq_ready, and head increments.
- enq_ready = ~full. It does not depend on deq_ready, so there is no combinational path from consumer to producer.
- deq_valid = ~empty.
- deq_instr/deq_pc show the head entry (show-ahead). They are forced to 0 when empty.
- count update:
  - +1 on enqueue only
  - −1 on dequeue only
  - unchanged when both or neither fire
- full, empty and almost_full decode combinationally from the count register.
- Priority per cycle: rst > flush > enqueue/dequeue.
- Flush:
  - head, tail and count go to 0.
  - Any enqueue or dequeue presented in the same cycle is dropped. The producer must re-present after flush.
- Reset: same effect as flush. Storage contents are not cleared and are don't-care.
- No bypass. An entry written in cycle N cannot be dequeued before cycle N+1.
- Enqueue while full cannot fire (enq_ready=0). The producer holds its data, and no entry is overwritten.
- Dequeue while empty cannot fire. head does not move.
- Simultaneous enqueue and dequeue at full is impossible, since enq_ready=0. At any other non-empty occupancy both fire and count is unchanged.

## Timing
- Output reset values:
  - enq_ready=1, deq_valid=0, deq_instr=0, deq_pc=0
  - count=0, full=0, empty=1, almost_full=0
- Enqueue-to-dequeue latency is 1 cycle. Entry accepted at edge N gives deq_valid=1 with that data after edge N.
- Sustained throughput is 1 entry/cycle on both sides when 0 < count < DEPTH.
- count and all flags update on the same edge as the pointer that changes them.
- Flush or rst asserted at edge N gives empty=1 and enq_ready=1 after edge N. Enqueue is possible at edge N+1.
- Reset mid-stream: outputs return to reset values after the first edge with rst=1, independent of enq/deq/flush.
- All outputs are functions of registered state only, except deq_instr/deq_pc, which are a read-mux of head storage.

## Test plan
- Reset, then enqueue 0x000170b3@PC 0x0, 0x0001f133@0x4, 0x000271b3@0x8 on back-to-back cycles with deq_ready=0:
  - count=3, empty=0, deq_instr=0x000170b3, deq_pc=0x0.
  - Then deq_ready=1 for 3 cycles: outputs are 0x000170b3, 0x0001f133, 0x000271b3 in order, then empty=1, deq_instr=0.
- DEPTH=8, AFULL_THRESH=6, enqueue 8 entries with no dequeue:
  - almost_full rises after the 6th accept, full and enq_ready=0 after the 8th.
  - A 9th enq_valid is not accepted, and count stays 8.
- Wrap-around: fill to 8, dequeue 5, enqueue 5 more (tail wraps), then drain 8. All 13 entries emerge in order with the correct PCs, and count returns to 0.
- Simultaneous enq+deq at count=4 for 10 cycles: count stays 4 and the output stream is in enqueue order.
- Flush at count=5 with enq_valid=1 and deq_ready=1 in the same cycle:
  - Next cycle count=0, empty=1, deq_valid=0, and the presented entry is not stored.
  - Next enqueue of 0x00b08093@0x40 appears at the head one cycle later.
- rst asserted at count=3: next cycle all outputs are at reset values, and a subsequent enqueue/dequeue works normally.

Source files
------------

// File: rtl/instr_queue.sv
// In-order instruction queue between fetch and issue: circular buffer of {instr, pc}
// with valid/ready on both sides, show-ahead head output and single-cycle flush.
module instr_queue #(
    parameter int WIDTH        = 32,
    parameter int PC_WIDTH     = 32,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [WIDTH-1:0]          enq_instr,
    input  logic [PC_WIDTH-1:0]       enq_pc,
    output logic                      deq_valid,
    input  logic                      deq_ready,
    output logic [WIDTH-1:0]          deq_instr,
    output logic [PC_WIDTH-1:0]       deq_pc,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [WIDTH-1:0]    instr_mem [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic                enq_fire;
    logic                deq_fire;

    // Flags come straight from the count register so no output sees deq_ready.
    assign full        = (count == CNT_FULL);
    assign empty       = (count == '0);
    assign almost_full = (count >= CNT_AFULL);
    assign enq_ready   = ~full;
    assign deq_valid   = ~empty;

    assign enq_fire = enq_valid & enq_ready;
    assign deq_fire = deq_valid & deq_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + PTR_ONE;
            end
            if (deq_fire) begin
                head <= head + PTR_ONE;
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage is never cleared; a flushed or reset entry is simply unreachable.
    always_ff @(posedge clk) begin
        if (!rst && !flush && enq_fire) begin
            instr_mem[tail] <= enq_instr;
            pc_mem[tail]    <= enq_pc;
        end
    end

    always_comb begin
        deq_instr = '0;
        deq_pc    = '0;
        if (!empty) begin
            deq_instr = instr_mem[head];
            deq_pc    = pc_mem[head];
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_instr_queue;

    localparam int WIDTH = 32;
    localparam int PC_WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 flush = 1'b0;
    logic                 enq_valid = 1'b0;
    logic                 enq_ready;
    logic [WIDTH-1:0]     enq_instr = '0;
    logic [PC_WIDTH-1:0]  enq_pc = '0;
    logic                 deq_valid;
    logic                 deq_ready = 1'b0;
    logic [WIDTH-1:0]     deq_instr;
    logic [PC_WIDTH-1:0]  deq_pc;
    logic [3:0]           count;
    logic                 full;
    logic                 empty;
    logic                 almost_full;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0]    m_instr [$];
    logic [PC_WIDTH-1:0] m_pc    [$];

    instr_queue #(
        .WIDTH(WIDTH), .PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_instr(enq_instr), .enq_pc(enq_pc),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_instr(deq_instr), .deq_pc(deq_pc),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    // Present inputs, take one rising edge, update the model, settle 1 time unit.
    task automatic drive_edge(input logic ev, input logic [WIDTH-1:0] ei,
                              input logic [PC_WIDTH-1:0] ep, input logic dr,
                              input logic fl, input logic r);
        bit do_enq;
        bit do_deq;
        enq_valid = ev;
        enq_instr = ei;
        enq_pc    = ep;
        deq_ready = dr;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        if (r || fl) begin
            m_instr.delete();
            m_pc.delete();
        end else begin
            do_enq = ev && (m_instr.size() < DEPTH);
            do_deq = dr && (m_instr.size() > 0);
            if (do_deq) begin
                void'(m_instr.pop_front());
                void'(m_pc.pop_front());
            end
            if (do_enq) begin
                m_instr.push_back(ei);
                m_pc.push_back(ep);
            end
        end
        #1;
    endtask

    task automatic idle();
        drive_edge(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive_edge(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_edge(1'b1, 32'hdead_beef, 32'h100, 1'b1, 1'b0, 1'b1);
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
        tests++; if (full !== 1'b0 || almost_full !== 1'b0) begin fails++; $display("FAIL reset_full_af got %b%b want 00", full, almost_full); end
        tests++; if (enq_ready !== 1'b1 || deq_valid !== 1'b0) begin fails++; $display("FAIL reset_handshake got rdy=%b vld=%b want 1 0", enq_ready, deq_valid); end
        tests++; if (deq_instr !== 32'h0 || deq_pc !== 32'h0) begin fails++; $display("FAIL reset_data got %h@%h want 0@0", deq_instr, deq_pc); end
        idle();
    endtask

    task automatic test_basic_order();
        logic [31:0] ins [3];
        ins[0] = 32'h0001_70b3; ins[1] = 32'h0001_f133; ins[2] = 32'h0002_71b3;
        do_reset();
        for (int i = 0; i < 3; i++) drive_edge(1'b1, ins[i], 32'(i * 4), 1'b0, 1'b0, 1'b0);
        tests++; if (count !== 4'd3 || empty !== 1'b0) begin fails++; $display("FAIL basic_count got %0d empty=%b want 3 0", count, empty); end
        tests++; if (deq_instr !== ins[0] || deq_pc !== 32'h0) begin fails++; $display("FAIL basic_head got %h@%h want %h@0", deq_instr, deq_pc, ins[0]); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (deq_valid !== 1'b1 || deq_instr !== ins[i] || deq_pc !== 32'(i * 4)) begin
                fails++; $display("FAIL basic_out%0d got v=%b %h@%h want 1 %h@%h", i, deq_valid, deq_instr, deq_pc, ins[i], i * 4);
            end
            drive_edge(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        end
        tests++; if (empty !== 1'b1 || deq_instr !== 32'h0 || count !== 4'd0) begin fails++; $display("FAIL basic_drained got empty=%b instr=%h cnt=%0d want 1 0 0", empty, deq_instr, count); end
        idle();
    endtask

    task automatic test_fill_full();
        logic [31:0] first;
        do_reset();
        first = $urandom;
        for (int i = 1; i <= DEPTH; i++) begin
            drive_edge(1'b1, (i == 1) ? first : 32'($urandom), 32'(i * 4), 1'b0, 1'b0, 1'b0);
            tests++;
            if (count !== 4'(i) || almost_full !== (i >= AFULL) || full !== (i == DEPTH) || enq_ready !== (i != DEPTH)) begin
                fails++; $display("FAIL fill_%0d got cnt=%0d af=%b full=%b rdy=%b", i, count, almost_full, full, enq_ready);
            end
        end
        drive_edge(1'b1, 32'h1234_5678, 32'h999, 1'b0, 1'b0, 1'b0);
        tests++; if (count !== 4'd8 || full !== 1'b1) begin fails++; $display("FAIL fill_overflow_count got %0d want 8", count); end
        tests++; if (deq_instr !== first || deq_pc !== 32'd4) begin fails++; $display("FAIL fill_overflow_head got %h@%h want %h@4", deq_instr, deq_pc, first); end
        idle();
    endtask

    task automatic test_wrap();
        logic [31:0] data [13];
        int k;
        do_reset();
        for (int i = 0; i < 13; i++) data[i] = $urandom;
        for (int i = 0; i < 8; i++) drive_edge(1'b1, data[i], 32'(32'h200 + i * 4), 1'b0, 1'b0, 1'b0);
        k = 0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (deq_instr !== data[k] || deq_pc !== 32'(32'h200 + k * 4)) begin
                fails++; $display("FAIL wrap_out%0d got %h@%h want %h@%h", k, deq_instr, deq_pc, data[k], 32'h200 + k * 4);
            end
            drive_edge(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            k++;
        end
        for (int i = 8; i < 13; i++) drive_edge(1'b1, data[i], 32'(32'h200 + i * 4), 1'b0, 1'b0, 1'b0);
        tests++; if (count !== 4'd8) begin fails++; $display("FAIL wrap_refill_count got %0d want 8", count); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (deq_instr !== data[k] || deq_pc !== 32'(32'h200 + k * 4)) begin
                fails++; $display("FAIL wrap_out%0d got %h@%h want %h@%h", k, deq_instr, deq_pc, data[k], 32'h200 + k * 4);
            end
            drive_edge(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            k++;
        end
        tests++; if (count !== 4'd0 || empty !== 1'b1) begin fails++; $display("FAIL wrap_drained got cnt=%0d empty=%b want 0 1", count, empty); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] data [14];
        int k;
        do_reset();
        for (int i = 0; i < 14; i++) data[i] = $urandom;
        for (int i = 0; i < 4; i++) drive_edge(1'b1, data[i], 32'(i), 1'b0, 1'b0, 1'b0);
        k = 0;
        for (int i = 4; i < 14; i++) begin
            tests++;
            if (deq_instr !== data[k] || deq_pc !== 32'(k)) begin
                fails++; $display("FAIL b2b_out%0d got %h@%h want %h@%h", k, deq_instr, deq_pc, data[k], k);
            end
            drive_edge(1'b1, data[i], 32'(i), 1'b1, 1'b0, 1'b0);
            k++;
            tests++; if (count !== 4'd4) begin fails++; $display("FAIL b2b_count%0d got %0d want 4", i, count); end
        end
        tests++; if (deq_instr !== data[10]) begin fails++; $display("FAIL b2b_tail_head got %h want %h", deq_instr, data[10]); end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) drive_edge(1'b1, 32'($urandom), 32'(i * 4), 1'b0, 1'b0, 1'b0);
        drive_edge(1'b1, 32'hffff_0001, 32'h80, 1'b1, 1'b1, 1'b0);
        tests++; if (count !== 4'd0 || empty !== 1'b1 || deq_valid !== 1'b0 || enq_ready !== 1'b1) begin
            fails++; $display("FAIL flush_state got cnt=%0d empty=%b vld=%b rdy=%b want 0 1 0 1", count, empty, deq_valid, enq_ready);
        end
        drive_edge(1'b1, 32'h00b0_8093, 32'h40, 1'b0, 1'b0, 1'b0);
        tests++; if (count !== 4'd1 || deq_valid !== 1'b1) begin fails++; $display("FAIL flush_reenq_count got cnt=%0d vld=%b want 1 1", count, deq_valid); end
        tests++; if (deq_instr !== 32'h00b0_8093 || deq_pc !== 32'h40) begin fails++; $display("FAIL flush_reenq_head got %h@%h want 00b08093@40", deq_instr, deq_pc); end
        idle();
    endtask

    task automatic test_rst_midstream();
        do_reset();
        for (int i = 0; i < 3; i++) drive_edge(1'b1, 32'($urandom), 32'(i * 4), 1'b0, 1'b0, 1'b0);
        drive_edge(1'b1, 32'hcafe_f00d, 32'h44, 1'b1, 1'b1, 1'b1);
        tests++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
                     enq_ready !== 1'b1 || deq_valid !== 1'b0 || deq_instr !== 32'h0 || deq_pc !== 32'h0) begin
            fails++; $display("FAIL rst_mid_state got cnt=%0d e=%b f=%b af=%b rdy=%b vld=%b %h@%h", count, empty, full, almost_full, enq_ready, deq_valid, deq_instr, deq_pc);
        end
        drive_edge(1'b1, 32'h0000_1337, 32'h60, 1'b0, 1'b0, 1'b0);
        tests++; if (deq_instr !== 32'h0000_1337 || deq_pc !== 32'h60 || count !== 4'd1) begin fails++; $display("FAIL rst_mid_enq got %h@%h cnt=%0d want 1337@60 1", deq_instr, deq_pc, count); end
        drive_edge(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        tests++; if (empty !== 1'b1 || count !== 4'd0) begin fails++; $display("FAIL rst_mid_deq got empty=%b cnt=%0d want 1 0", empty, count); end
        idle();
    endtask

    task automatic test_random();
        logic ev, dr, fl, r;
        int sz;
        logic [31:0] hi, hp;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            ev = ($urandom_range(0, 99) < 60);
            dr = ($urandom_range(0, 99) < 50);
            fl = ($urandom_range(0, 99) < 3);
            r  = ($urandom_range(0, 199) < 1);
            drive_edge(ev, 32'($urandom), 32'($urandom), dr, fl, r);
            sz = m_instr.size();
            hi = (sz > 0) ? m_instr[0] : 32'h0;
            hp = (sz > 0) ? m_pc[0] : 32'h0;
            tests++;
            if (count !== 4'(sz) || empty !== (sz == 0) || full !== (sz == DEPTH) || almost_full !== (sz >= AFULL) ||
                enq_ready !== (sz != DEPTH) || deq_valid !== (sz != 0) || deq_instr !== hi || deq_pc !== hp) begin
                fails++;
                $display("FAIL random_%0d got cnt=%0d e=%b f=%b af=%b rdy=%b vld=%b %h@%h want cnt=%0d %h@%h",
                         n, count, empty, full, almost_full, enq_ready, deq_valid, deq_instr, deq_pc, sz, hi, hp);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_fill_full();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_rst_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
